// File: rtl/audio_filter_bank.sv
// audio_filter_bank
// Multi-channel first-order IIR filter bank between the codec receive side and
// the DAC transmit side. One shared datapath walks the channels one per clock
// after each frame tick. Modes: bypass, lowpass, highpass, bandpass, with
// runtime cutoff shifts. A mode change is blended in over 2^FADE_LOG2 samples.
//
// Ports:
//   AUD_BCLK       - sole clock, rising edge
//   reset          - asynchronous, active-high reset
//   AUD_DACLRCK    - frame clock; its synchronized rising edge is the sample tick
//   audio_in       - CHANNELS packed signed samples, channel 0 in the LSBs
//   filter_choice  - 00 bypass, 01 lowpass, 10 highpass, 11 bandpass
//   lp_shift       - lowpass coefficient, alpha = 2^-lp_shift
//   hp_shift       - highpass / bandpass-low coefficient, alpha = 2^-hp_shift
//   audio_out      - registered packed output samples, held between frames
//   out_valid      - one-cycle pulse when audio_out updates
//   busy           - high while channels are being processed
//   choice_display - mode currently targeted
module audio_filter_bank #(
  parameter int DATA_W    = 32,
  parameter int CHANNELS  = 2,
  parameter int SHIFT_W   = 4,
  parameter int FADE_LOG2 = 4
) (
  input  logic                         AUD_BCLK,
  input  logic                         reset,
  input  logic                         AUD_DACLRCK,
  input  logic [CHANNELS*DATA_W-1:0]   audio_in,
  input  logic [1:0]                   filter_choice,
  input  logic [SHIFT_W-1:0]           lp_shift,
  input  logic [SHIFT_W-1:0]           hp_shift,
  output logic [CHANNELS*DATA_W-1:0]   audio_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic [1:0]                   choice_display
);

  // Wide enough for a sample times a fade weight plus headroom for the sum.
  localparam int WIDE = DATA_W + FADE_LOG2 + 3;
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [FADE_LOG2:0] K_FULL = {1'b1, {FADE_LOG2{1'b0}}};
  localparam logic [FADE_LOG2:0] K_ONE  = {{FADE_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, next_state;

  logic lrck_s1, lrck_s2, lrck_d, tick;
  logic capture, last_ch;
  logic [CH_W-1:0] ch;

  logic signed [DATA_W-1:0] x_cap   [CHANNELS];
  logic signed [DATA_W-1:0] a_acc   [CHANNELS];
  logic signed [DATA_W-1:0] b_acc   [CHANNELS];
  logic signed [DATA_W-1:0] out_buf [CHANNELS];
  logic [SHIFT_W-1:0] lp_cap, hp_cap;
  logic [1:0] target_mode, old_mode;
  logic fading;
  logic [FADE_LOG2:0] fade_k;

  logic signed [DATA_W-1:0] x_cur, a_cur, b_cur, a_new, b_new, y_new, y_old, ch_out;
  logic signed [DATA_W:0] da, db, da_sh, db_sh;
  logic signed [WIDE-1:0] w_new, w_old, mix;
  logic [CHANNELS*DATA_W-1:0] out_next;

  function automatic logic signed [WIDE-1:0] ext(input logic signed [DATA_W-1:0] v);
    return {{(WIDE-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [WIDE-1:0] ext1(input logic signed [DATA_W:0] v);
    return {{(WIDE-DATA_W-1){v[DATA_W]}}, v};
  endfunction

  // Clamp to the signed DATA_W range: in range only if every bit above the
  // sample's sign bit matches it.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [WIDE-1:0] v);
    logic [WIDE-DATA_W:0] top;
    top = v[WIDE-1:DATA_W-1];
    if (top == '0 || top == '1) return v[DATA_W-1:0];
    else if (v[WIDE-1])         return {1'b1, {(DATA_W-1){1'b0}}};
    else                        return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  function automatic logic signed [DATA_W-1:0] mode_out(
    input logic [1:0] m,
    input logic signed [DATA_W-1:0] x, a, b
  );
    case (m)
      2'b00:   return x;
      2'b01:   return a;
      2'b10:   return sat(ext(x) - ext(b));
      default: return sat(ext(a) - ext(b));
    endcase
  endfunction

  // Frame clock synchronizer and rising-edge detector; tick is registered, so it
  // lands three clocks after the frame clock rises.
  always_ff @(posedge AUD_BCLK or posedge reset) begin
    if (reset) begin
      lrck_s1 <= 1'b0;
      lrck_s2 <= 1'b0;
      lrck_d  <= 1'b0;
      tick    <= 1'b0;
    end else begin
      lrck_s1 <= AUD_DACLRCK;
      lrck_s2 <= lrck_s1;
      lrck_d  <= lrck_s2;
      tick    <= lrck_s2 & ~lrck_d;
    end
  end

  assign capture        = tick && (state == IDLE);
  assign last_ch        = (ch == CH_W'(CHANNELS - 1));
  assign choice_display = target_mode;

  // FSM state register.
  always_ff @(posedge AUD_BCLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // FSM next state; ticks outside IDLE are simply never looked at.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (capture) next_state = CALC;
      CALC:    if (last_ch) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state == CALC);
  end

  // Per-channel arithmetic for the channel selected by ch. Both accumulators
  // always advance; the old and new mode outputs are blended while fading.
  always_comb begin
    x_cur = x_cap[ch];
    a_cur = a_acc[ch];
    b_cur = b_acc[ch];
    da    = {x_cur[DATA_W-1], x_cur} - {a_cur[DATA_W-1], a_cur};
    db    = {x_cur[DATA_W-1], x_cur} - {b_cur[DATA_W-1], b_cur};
    da_sh = da >>> lp_cap;
    db_sh = db >>> hp_cap;
    a_new = sat(ext(a_cur) + ext1(da_sh));
    b_new = sat(ext(b_cur) + ext1(db_sh));
    y_new = mode_out(target_mode, x_cur, a_new, b_new);
    y_old = mode_out(old_mode, x_cur, a_new, b_new);
    w_new = {{(WIDE-FADE_LOG2-1){1'b0}}, fade_k};
    w_old = {{(WIDE-FADE_LOG2-1){1'b0}}, K_FULL - fade_k};
    mix   = (ext(y_old) * w_old + ext(y_new) * w_new) >>> FADE_LOG2;
    ch_out = fading ? sat(mix) : y_new;
  end

  // Output word for the final channel: earlier channels come from out_buf.
  always_comb begin
    out_next = audio_out;
    for (int c = 0; c < CHANNELS; c++)
      out_next[c*DATA_W +: DATA_W] = (ch == CH_W'(c)) ? ch_out : out_buf[c];
  end

  // Datapath: frame capture and mode-change bookkeeping on an accepted tick,
  // accumulator write-back per channel, and the output update on the last one.
  always_ff @(posedge AUD_BCLK or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        x_cap[c]   <= '0;
        a_acc[c]   <= '0;
        b_acc[c]   <= '0;
        out_buf[c] <= '0;
      end
      ch          <= '0;
      lp_cap      <= '0;
      hp_cap      <= '0;
      target_mode <= 2'b00;
      old_mode    <= 2'b00;
      fading      <= 1'b0;
      fade_k      <= '0;
      audio_out   <= '0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (capture) begin
        for (int c = 0; c < CHANNELS; c++)
          x_cap[c] <= audio_in[c*DATA_W +: DATA_W];
        lp_cap <= lp_shift;
        hp_cap <= hp_shift;
        ch     <= '0;
        if (filter_choice != target_mode) begin
          old_mode    <= target_mode;
          target_mode <= filter_choice;
          fading      <= 1'b1;
          fade_k      <= K_ONE;
        end
      end
      if (state == CALC) begin
        a_acc[ch]   <= a_new;
        b_acc[ch]   <= b_new;
        out_buf[ch] <= ch_out;
        if (last_ch) begin
          audio_out <= out_next;
          out_valid <= 1'b1;
          if (fading) begin
            if (fade_k == K_FULL) fading <= 1'b0;
            else                  fade_k <= fade_k + K_ONE;
          end
        end else begin
          ch <= ch + CH_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_filter_bank.sv
// Directed testbench for audio_filter_bank (2 channels, 32-bit, 4-sample fade).
module tb_audio_filter_bank;

  localparam int DATA_W    = 32;
  localparam int CHANNELS  = 2;
  localparam int SHIFT_W   = 4;
  localparam int FADE_LOG2 = 2;

  logic                       AUD_BCLK = 1'b0;
  logic                       reset;
  logic                       AUD_DACLRCK;
  logic [CHANNELS*DATA_W-1:0] audio_in;
  logic [1:0]                 filter_choice;
  logic [SHIFT_W-1:0]         lp_shift;
  logic [SHIFT_W-1:0]         hp_shift;
  logic [CHANNELS*DATA_W-1:0] audio_out;
  logic                       out_valid;
  logic                       busy;
  logic [1:0]                 choice_display;

  int total = 0;
  int bad   = 0;

  // 10 ns bit clock.
  always #5 AUD_BCLK = ~AUD_BCLK;

  audio_filter_bank #(
    .DATA_W(DATA_W), .CHANNELS(CHANNELS), .SHIFT_W(SHIFT_W), .FADE_LOG2(FADE_LOG2)
  ) dut (
    .AUD_BCLK(AUD_BCLK),
    .reset(reset),
    .AUD_DACLRCK(AUD_DACLRCK),
    .audio_in(audio_in),
    .filter_choice(filter_choice),
    .lp_shift(lp_shift),
    .hp_shift(hp_shift),
    .audio_out(audio_out),
    .out_valid(out_valid),
    .busy(busy),
    .choice_display(choice_display)
  );

  // Overall time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic signed [31:0] x0, input logic signed [31:0] x1,
                               input logic [1:0] choice, input logic [3:0] lp, input logic [3:0] hp);
    audio_in      = {x1, x0};
    filter_choice = choice;
    lp_shift      = lp;
    hp_shift      = hp;
  endtask

  // One frame: raise the frame clock, wait (bounded) for out_valid, report the
  // latency in clocks from the rise (-1 on timeout) and both output samples.
  task automatic run_frame(input logic signed [31:0] x0, input logic signed [31:0] x1,
                           input logic [1:0] choice, input logic [3:0] lp, input logic [3:0] hp,
                           output int lat, output logic signed [31:0] y0,
                           output logic signed [31:0] y1);
    @(negedge AUD_BCLK);
    applyStimulus(x0, x1, choice, lp, hp);
    AUD_DACLRCK = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge AUD_BCLK);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    y0 = audio_out[31:0];
    y1 = audio_out[63:32];
    AUD_DACLRCK = 1'b0;
    repeat (5) @(negedge AUD_BCLK);
  endtask

  // Run several zero-shift frames so the mode settles and accumulators equal x.
  task automatic settle(input logic [1:0] mode, input logic signed [31:0] x0,
                        input logic signed [31:0] x1);
    int lat;
    logic signed [31:0] y0, y1;
    for (int i = 0; i < 5; i++) run_frame(x0, x1, mode, 4'd0, 4'd0, lat, y0, y1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    AUD_DACLRCK = 1'b0;
    applyStimulus(0, 0, 2'b00, 4'd0, 4'd0);
    repeat (3) @(negedge AUD_BCLK);
    total++; if (audio_out !== '0) begin bad++; $display("[TB] FAIL reset audio_out got=%h want=0", audio_out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset busy got=%b want=0", busy); end
    total++; if (choice_display !== 2'b00) begin bad++; $display("[TB] FAIL reset choice got=%b want=00", choice_display); end
    reset = 1'b0;
    repeat (3) @(negedge AUD_BCLK);
  endtask

  // Cycle-by-cycle view of one bypass frame: tick at clock 3, busy at 4..5,
  // out_valid at 6 (three clocks after the tick).
  task automatic test_bypass();
    logic [8:1] vh, bh;
    logic [63:0] got;
    got = '0;
    @(negedge AUD_BCLK);
    applyStimulus(1000, -5, 2'b00, 4'd0, 4'd0);
    AUD_DACLRCK = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge AUD_BCLK);
      vh[i] = out_valid;
      bh[i] = busy;
      if (i == 6) got = audio_out;
    end
    total++; if (vh !== 8'b0010_0000) begin bad++; $display("[TB] FAIL bypass out_valid_timing got=%b want=00100000", vh); end
    total++; if (bh !== 8'b0001_1000) begin bad++; $display("[TB] FAIL bypass busy_timing got=%b want=00011000", bh); end
    total++; if (got !== {32'hFFFF_FFFB, 32'd1000}) begin bad++; $display("[TB] FAIL bypass data got=%h want=fffffffb000003e8", got); end
    AUD_DACLRCK = 1'b0;
    repeat (5) @(negedge AUD_BCLK);
    total++; if (audio_out !== {32'hFFFF_FFFB, 32'd1000}) begin bad++; $display("[TB] FAIL bypass hold got=%h want=fffffffb000003e8", audio_out); end
  endtask

  task automatic test_lowpass();
    int lat;
    logic signed [31:0] y0, y1;
    int e0[5];
    int e1[5];
    e0 = '{500, 750, 875, 937, 968};
    e1 = '{-500, -750, -875, -938, -969};
    settle(2'b01, 0, 0);
    for (int i = 0; i < 5; i++) begin
      run_frame(1000, -1000, 2'b01, 4'd1, 4'd0, lat, y0, y1);
      total++; if (y0 !== e0[i]) begin bad++; $display("[TB] FAIL lowpass ch0 step %0d got=%0d want=%0d", i, y0, e0[i]); end
      total++; if (y1 !== e1[i]) begin bad++; $display("[TB] FAIL lowpass ch1 step %0d got=%0d want=%0d", i, y1, e1[i]); end
    end
  endtask

  // Residual is x minus a floor-rounded accumulator, so positive input rounds
  // the residual up and negative input rounds it toward zero.
  task automatic test_highpass();
    int lat;
    logic signed [31:0] y0, y1;
    int e0[5];
    int e1[5];
    e0 = '{500, 250, 125, 63, 32};
    e1 = '{-500, -250, -125, -62, -31};
    settle(2'b10, 0, 0);
    for (int i = 0; i < 5; i++) begin
      run_frame(1000, -1000, 2'b10, 4'd0, 4'd1, lat, y0, y1);
      total++; if (y0 !== e0[i]) begin bad++; $display("[TB] FAIL highpass ch0 step %0d got=%0d want=%0d", i, y0, e0[i]); end
      total++; if (y1 !== e1[i]) begin bad++; $display("[TB] FAIL highpass ch1 step %0d got=%0d want=%0d", i, y1, e1[i]); end
    end
  endtask

  task automatic test_bandpass();
    int lat;
    logic signed [31:0] y0, y1;
    int e0[2];
    int e1[2];
    e0 = '{250, 313};
    e1 = '{-250, -312};
    settle(2'b11, 0, 0);
    for (int i = 0; i < 2; i++) begin
      run_frame(1000, -1000, 2'b11, 4'd1, 4'd2, lat, y0, y1);
      total++; if (y0 !== e0[i]) begin bad++; $display("[TB] FAIL bandpass ch0 step %0d got=%0d want=%0d", i, y0, e0[i]); end
      total++; if (y1 !== e1[i]) begin bad++; $display("[TB] FAIL bandpass ch1 step %0d got=%0d want=%0d", i, y1, e1[i]); end
    end
  endtask

  task automatic test_crossfade();
    int lat;
    logic signed [31:0] y0, y1;
    int e0[5];
    int e1[5];
    e0 = '{750, 500, 250, 0, 0};
    e1 = '{-750, -500, -250, 0, 0};
    settle(2'b00, 1000, -1000);
    run_frame(1000, -1000, 2'b00, 4'd0, 4'd0, lat, y0, y1);
    total++; if (y0 !== 1000) begin bad++; $display("[TB] FAIL fade settled_bypass got=%0d want=1000", y0); end
    total++; if (choice_display !== 2'b00) begin bad++; $display("[TB] FAIL fade choice_before got=%b want=00", choice_display); end
    for (int i = 0; i < 5; i++) begin
      run_frame(1000, -1000, 2'b10, 4'd0, 4'd0, lat, y0, y1);
      if (i == 0) begin
        total++; if (choice_display !== 2'b10) begin bad++; $display("[TB] FAIL fade choice_first got=%b want=10", choice_display); end
      end
      total++; if (y0 !== e0[i]) begin bad++; $display("[TB] FAIL fade ch0 step %0d got=%0d want=%0d", i, y0, e0[i]); end
      total++; if (y1 !== e1[i]) begin bad++; $display("[TB] FAIL fade ch1 step %0d got=%0d want=%0d", i, y1, e1[i]); end
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic signed [31:0] y0, y1;
    run_frame(32'sh8000_0000, 32'sh7FFF_FFFF, 2'b10, 4'd0, 4'd0, lat, y0, y1);
    total++; if (y0 !== 0) begin bad++; $display("[TB] FAIL sat preload ch0 got=%0d want=0", y0); end
    run_frame(32'sh7FFF_FFFF, 32'sh8000_0000, 2'b10, 4'd0, 4'd15, lat, y0, y1);
    total++; if (y0 !== 32'sh7FFF_FFFF) begin bad++; $display("[TB] FAIL sat pos got=%h want=7fffffff", y0); end
    total++; if (y1 !== 32'sh8000_0000) begin bad++; $display("[TB] FAIL sat neg got=%h want=80000000", y1); end
  endtask

  task automatic test_reset_mid_calc();
    int lat, pulses;
    logic signed [31:0] y0, y1;
    @(negedge AUD_BCLK);
    applyStimulus(7, 7, 2'b10, 4'd0, 4'd0);
    AUD_DACLRCK = 1'b1;
    repeat (5) @(negedge AUD_BCLK);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midreset busy_before got=%b want=1", busy); end
    reset = 1'b1;
    AUD_DACLRCK = 1'b0;
    #1;
    total++; if (audio_out !== '0) begin bad++; $display("[TB] FAIL midreset audio_out got=%h want=0", audio_out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset busy got=%b want=0", busy); end
    total++; if (choice_display !== 2'b00) begin bad++; $display("[TB] FAIL midreset choice got=%b want=00", choice_display); end
    repeat (2) @(negedge AUD_BCLK);
    reset = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge AUD_BCLK);
      if (out_valid) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL midreset stray_valid got=%0d want=0", pulses); end
    // Fresh state: bypass -> highpass fade step 1 with b starting at 0.
    run_frame(1000, -1000, 2'b10, 4'd0, 4'd1, lat, y0, y1);
    total++; if (lat !== 6) begin bad++; $display("[TB] FAIL midreset latency got=%0d want=6", lat); end
    total++; if (y0 !== 875) begin bad++; $display("[TB] FAIL midreset ch0 got=%0d want=875", y0); end
    total++; if (y1 !== -875) begin bad++; $display("[TB] FAIL midreset ch1 got=%0d want=-875", y1); end
  endtask

  // Second frame-clock rise placed so its tick lands during CALC.
  task automatic test_back_to_back();
    int pulses, lat;
    logic signed [31:0] y0, y1;
    pulses = 0;
    @(negedge AUD_BCLK);
    applyStimulus(100, 100, 2'b10, 4'd0, 4'd0);
    AUD_DACLRCK = 1'b1;
    @(negedge AUD_BCLK);
    if (out_valid) pulses++;
    AUD_DACLRCK = 1'b0;
    @(negedge AUD_BCLK);
    if (out_valid) pulses++;
    AUD_DACLRCK = 1'b1;
    repeat (20) begin
      @(negedge AUD_BCLK);
      if (out_valid) pulses++;
    end
    total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL busy_tick pulses got=%0d want=1", pulses); end
    AUD_DACLRCK = 1'b0;
    repeat (5) @(negedge AUD_BCLK);
    run_frame(100, 100, 2'b10, 4'd0, 4'd0, lat, y0, y1);
    total++; if (lat !== 6) begin bad++; $display("[TB] FAIL busy_tick next_latency got=%0d want=6", lat); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_lowpass();
    test_highpass();
    test_bandpass();
    test_crossfade();
    test_saturation();
    test_reset_mid_calc();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
